step3: RTL



---
 rtl/pomdp_pkg.sv | 40 ++++
 rtl/step3_dot_argmax.sv | 50 +++++
 rtl/step3.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pomdp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pomdp_pkg
//  Description : Shared constants, types and arithmetic helpers for the PBVI
//                pipeline stages (alpha-vector selection).
//  Revision    : 1.0 - initial release
// ============================================================================
package pomdp_pkg;

    localparam int DW         = 16;
    localparam int NUM_BELIEF = 16;
    localparam int NUM_ACTION = 3;
    localparam int NUM_STATE  = 2;
    localparam int AW         = 2;

    typedef logic [DW-1:0]                 word_t;
    typedef word_t [NUM_STATE-1:0]         alpha_vec_t;
    typedef logic [AW-1:0]                 action_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } step3_state_e;

    // Belief is unsigned Q0.16, so the upper half of the 32-bit accumulator
    // is the dot product in alpha units. The accumulator wraps mod 2^32.
    function automatic word_t dot_fn(input alpha_vec_t belief, input alpha_vec_t alpha);
        logic [2*DW-1:0] acc;
        acc = '0;
        for (int s = 0; s < NUM_STATE; s++) begin
            acc = acc + ({{DW{1'b0}}, belief[s]} * {{DW{1'b0}}, alpha[s]});
        end
        return acc[2*DW-1:DW];
    endfunction

endpackage
`default_nettype wire

// File: rtl/step3_dot_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : step3_dot_argmax
//  Description : Combinational dot product of one belief point against every
//                candidate alpha, followed by an unsigned argmax. Ties resolve
//                to the lowest action index.
//  Revision    : 1.0 - initial release
// ============================================================================
module step3_dot_argmax
    import pomdp_pkg::*;
(
    input  logic [DW-1:0] belief [NUM_STATE],
    input  logic [DW-1:0] alpha  [NUM_ACTION][NUM_STATE],
    output logic [AW-1:0] win_action,
    output logic [DW-1:0] win_dot
);

    alpha_vec_t w_belief;
    alpha_vec_t w_alpha [NUM_ACTION];
    word_t      w_dot   [NUM_ACTION];

    // Pack the vectors, form every dot product and keep the strict maximum.
    always_comb begin
        w_belief   = '0;
        win_action = '0;
        win_dot    = '0;
        for (int a = 0; a < NUM_ACTION; a++) begin
            w_alpha[a] = '0;
            w_dot[a]   = '0;
        end
        for (int s = 0; s < NUM_STATE; s++) begin
            w_belief[s] = belief[s];
        end
        for (int a = 0; a < NUM_ACTION; a++) begin
            for (int s = 0; s < NUM_STATE; s++) begin
                w_alpha[a][s] = alpha[a][s];
            end
            w_dot[a] = dot_fn(w_belief, w_alpha[a]);
        end
        win_dot = w_dot[0];
        for (int a = 1; a < NUM_ACTION; a++) begin
            if (w_dot[a] > win_dot) begin
                win_dot    = w_dot[a];
                win_action = AW'(a);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/step3.sv
`default_nettype none
// ============================================================================
//  Module      : step3
//  Description : PBVI alpha selection. Buffers the per-action candidate alphas
//                and belief points, then for each belief picks the action with
//                the largest dot product (one belief per cycle, two stages) and
//                pulses en_step4 when the whole set has been written.
//  Revision    : 1.0 - initial release
// ============================================================================
module step3
    import pomdp_pkg::*;
#(
    parameter int DW         = pomdp_pkg::DW,
    parameter int NUM_BELIEF = pomdp_pkg::NUM_BELIEF,
    parameter int NUM_ACTION = pomdp_pkg::NUM_ACTION,
    parameter int NUM_STATE  = pomdp_pkg::NUM_STATE,
    parameter int AW         = pomdp_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] gamma_action_belief [NUM_ACTION][NUM_BELIEF][NUM_STATE],
    input  logic [DW-1:0] point_belief        [NUM_BELIEF][NUM_STATE],
    output logic [DW-1:0] alpha_out           [NUM_BELIEF][NUM_STATE],
    output logic [AW-1:0] action_out          [NUM_BELIEF],
    output logic [DW-1:0] value_out           [NUM_BELIEF],
    output logic          busy,
    output logic          en_step4
);

    localparam int             IW     = $clog2(NUM_BELIEF);
    localparam logic [IW-1:0]  C_LAST = IW'(NUM_BELIEF - 1);

    step3_state_e  r_state;
    logic [IW-1:0] r_idx;

    logic [DW-1:0] r_gamma  [NUM_ACTION][NUM_BELIEF][NUM_STATE];
    logic [DW-1:0] r_belief [NUM_BELIEF][NUM_STATE];

    logic          r_s1_valid;
    logic [IW-1:0] r_s1_idx;
    logic [AW-1:0] r_s1_action;
    logic [DW-1:0] r_s1_value;

    logic [DW-1:0] w_belief [NUM_STATE];
    logic [DW-1:0] w_alpha  [NUM_ACTION][NUM_STATE];
    logic [AW-1:0] w_win_action;
    logic [DW-1:0] w_win_dot;

    // Present the buffered belief/candidates for the current index.
    for (genvar s = 0; s < NUM_STATE; s++) begin : g_bel
        assign w_belief[s] = r_belief[r_idx][s];
    end

    for (genvar a = 0; a < NUM_ACTION; a++) begin : g_act
        for (genvar s = 0; s < NUM_STATE; s++) begin : g_st
            assign w_alpha[a][s] = r_gamma[a][r_idx][s];
        end
    end

    step3_dot_argmax u_dot_argmax (
        .belief     (w_belief),
        .alpha      (w_alpha),
        .win_action (w_win_action),
        .win_dot    (w_win_dot)
    );

    // Capture upstream results during LOAD; they are not looked at otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BELIEF; i++) begin
                for (int s = 0; s < NUM_STATE; s++) begin
                    r_belief[i][s] <= '0;
                    for (int a = 0; a < NUM_ACTION; a++) begin
                        r_gamma[a][i][s] <= '0;
                    end
                end
            end
        end else if (r_state == S_LOAD) begin
            for (int i = 0; i < NUM_BELIEF; i++) begin
                for (int s = 0; s < NUM_STATE; s++) begin
                    r_belief[i][s] <= point_belief[i][s];
                    for (int a = 0; a < NUM_ACTION; a++) begin
                        r_gamma[a][i][s] <= gamma_action_belief[a][i][s];
                    end
                end
            end
        end
    end

    // Sequencer and stage 1: walk the belief index and register each winner.
    // A new en outside IDLE/DONE abandons the current run and reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_idx    <= '0;
            r_s1_action <= '0;
            r_s1_value  <= '0;
            busy        <= 1'b0;
            en_step4    <= 1'b0;
        end else begin
            en_step4   <= 1'b0;
            r_s1_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_LOAD;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_idx <= '0;
                    if (!en) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (en) begin
                        r_state <= S_LOAD;
                        r_idx   <= '0;
                    end else begin
                        r_s1_valid  <= 1'b1;
                        r_s1_idx    <= r_idx;
                        r_s1_action <= w_win_action;
                        r_s1_value  <= w_win_dot;
                        r_idx       <= r_idx + IW'(1);
                        if (r_idx == C_LAST) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (en) begin
                        r_state <= S_LOAD;
                        r_idx   <= '0;
                    end else begin
                        r_state  <= S_DONE;
                        busy     <= 1'b0;
                        en_step4 <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (en) begin
                        r_state <= S_LOAD;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Stage 2: write the winning action, value and alpha for the staged entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BELIEF; i++) begin
                action_out[i] <= '0;
                value_out[i]  <= '0;
                for (int s = 0; s < NUM_STATE; s++) begin
                    alpha_out[i][s] <= '0;
                end
            end
        end else if (r_s1_valid) begin
            action_out[r_s1_idx] <= r_s1_action;
            value_out[r_s1_idx]  <= r_s1_value;
            for (int s = 0; s < NUM_STATE; s++) begin
                alpha_out[r_s1_idx][s] <= r_gamma[r_s1_action][r_s1_idx][s];
            end
        end
    end

endmodule
`default_nettype wire
